// File: rtl/guess_pkg.sv
// Shared types and constants for the guessing-game scorekeeper.
// Holds the round FSM states, seven-segment glyphs and digit enables.
package guess_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } score_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        glyph = SEG_BLANK;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter 00..99, saturating at 99; result registered, 1-cycle latency.
// No backpressure: clr wins over a same-cycle inc.
module bcd_counter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       at_max;

    assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign q = {tens_q, ones_q};

endmodule

// File: rtl/guess_score.sv
// Win/loss scorekeeper with 4-digit multiplexed display; tallies 1 cycle, display 1 further cycle.
// No backpressure: one count per flag assertion, flags held for any length are counted once.
module guess_score
    import guess_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       win,
    input  logic       lose,
    input  logic       clr,
    output logic [7:0] win_bcd,
    output logic [7:0] lose_bcd,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    score_state_t     state_q, state_d;
    logic             win_inc, lose_inc;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib;

    // Round FSM: count on entry to HOLD, rearm only once both flags drop
    always_comb begin
        state_d  = state_q;
        win_inc  = 1'b0;
        lose_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (win && !lose) begin
                    win_inc = 1'b1;
                    state_d = HOLD;
                end else if (lose && !win) begin
                    lose_inc = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!win && !lose) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    bcd_counter2 u_win_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (win_inc),
        .q   (win_bcd)
    );

    bcd_counter2 u_lose_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (lose_inc),
        .q   (lose_bcd)
    );

    // Scan: an/seg are loaded for the digit that will be active after this edge
    always_comb begin
        div_d = div_q + DIV_W'(1);
        dig_d = dig_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            dig_d = dig_q + 2'd1;
        end
        an_d = AN_D0;
        nib  = win_bcd[3:0];
        case (dig_d)
            2'd0: begin an_d = AN_D0; nib = win_bcd[3:0];  end
            2'd1: begin an_d = AN_D1; nib = win_bcd[7:4];  end
            2'd2: begin an_d = AN_D2; nib = lose_bcd[3:0]; end
            2'd3: begin an_d = AN_D3; nib = lose_bcd[7:4]; end
            default: begin an_d = AN_D0; nib = win_bcd[3:0]; end
        endcase
        seg_d = seg_glyph(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            dig_q <= 2'd0;
            an_q  <= AN_D0;
            seg_q <= SEG_0;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_guess_score.sv
// Randomized and directed bench for guess_score against a behavioural score/display model.
module tb_guess_score;

    logic       clk = 1'b0;
    logic       rst;
    logic       win;
    logic       lose;
    logic       clr;
    logic [7:0] win_bcd;
    logic [7:0] lose_bcd;
    logic [3:0] an;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: decimal counts, a "waiting for release" flag, edges since reset
    int m_wins, m_loses, m_cyc;
    bit m_busy;
    int d_wins, d_loses;

    always #5 clk = ~clk;

    guess_score #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .win      (win),
        .lose     (lose),
        .clr      (clr),
        .win_bcd  (win_bcd),
        .lose_bcd (lose_bcd),
        .an       (an),
        .seg      (seg)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int k);
        case (k)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wins  = 0;
        m_loses = 0;
        m_busy  = 1'b0;
        m_cyc   = 0;
        d_wins  = 0;
        d_loses = 0;
    endtask

    task automatic check_all();
        int k, v;
        k = (m_cyc / 4) % 4;
        case (k)
            0: v = d_wins % 10;
            1: v = d_wins / 10;
            2: v = d_loses % 10;
            default: v = d_loses / 10;
        endcase
        chk("win_bcd", 32'(win_bcd), 32'(to_bcd(m_wins)));
        chk("lose_bcd", 32'(lose_bcd), 32'(to_bcd(m_loses)));
        chk("ones_range", 32'(win_bcd[3:0] <= 4'd9 && lose_bcd[3:0] <= 4'd9), 32'd1);
        chk("an", 32'(an), 32'(exp_an(k)));
        chk("seg", 32'(seg), 32'(exp_glyph(v)));
    endtask

    // One clock: drive, advance the model on the edge, check 1 time unit later
    task automatic step(input logic w, input logic l, input logic c);
        win  = w;
        lose = l;
        clr  = c;
        @(posedge clk);
        d_wins  = m_wins;
        d_loses = m_loses;
        m_cyc++;
        if (c) begin
            m_wins  = 0;
            m_loses = 0;
            m_busy  = 1'b0;
        end else if (!m_busy) begin
            if (w && !l) begin
                if (m_wins < 99) m_wins++;
                m_busy = 1'b1;
            end else if (l && !w) begin
                if (m_loses < 99) m_loses++;
                m_busy = 1'b1;
            end
        end else if (!w && !l) begin
            m_busy = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic win_round();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic lose_round();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] an_seq  [4];
    logic [6:0] seg_seq [4];
    logic       rw, rl;
    int         r;

    initial begin
        rst  = 1'b1;
        win  = 1'b0;
        lose = 1'b0;
        clr  = 1'b0;
        model_reset();
        #2;
        check_all();
        #1 rst = 1'b0;

        // Single long win: counted once
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("win_held", 32'(win_bcd), 32'h01);
        chk("lose_held", 32'(lose_bcd), 32'h00);
        step(1'b0, 1'b0, 1'b0);

        // Held and swapped flags
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("swap_win", 32'(win_bcd), 32'h01);
        chk("swap_lose", 32'(lose_bcd), 32'h01);

        // BCD wrap and saturation
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) win_round();
        chk("wins_09", 32'(win_bcd), 32'h09);
        win_round();
        chk("wins_10", 32'(win_bcd), 32'h10);
        for (int i = 0; i < 89; i++) win_round();
        chk("wins_99", 32'(win_bcd), 32'h99);
        win_round();
        chk("wins_sat", 32'(win_bcd), 32'h99);

        // Illegal both-high and clr priority
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("illegal_win", 32'(win_bcd), 32'h00);
        chk("illegal_lose", 32'(lose_bcd), 32'h00);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_prio_win", 32'(win_bcd), 32'h00);
        chk("clr_prio_lose", 32'(lose_bcd), 32'h00);
        step(1'b1, 1'b0, 1'b0);
        chk("after_clr_count", 32'(win_bcd), 32'h01);
        step(1'b0, 1'b0, 1'b0);

        // Display scan with wins=37, losses=05
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 37; i++) win_round();
        for (int i = 0; i < 5; i++) lose_round();
        an_seq[0]  = 4'b1110; an_seq[1]  = 4'b1101; an_seq[2]  = 4'b1011; an_seq[3]  = 4'b0111;
        seg_seq[0] = 7'b1111000; seg_seq[1] = 7'b0110000;
        seg_seq[2] = 7'b0010010; seg_seq[3] = 7'b1000000;
        while ((m_cyc % 16) != 0) step(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 32; j++) begin
            chk("scan_an", 32'(an), 32'(an_seq[(j / 4) % 4]));
            chk("scan_seg", 32'(seg), 32'(seg_seq[(j / 4) % 4]));
            step(1'b0, 1'b0, 1'b0);
        end

        // Randomized flags held for random lengths, occasional clr
        rw = 1'b0;
        rl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r  = $urandom_range(0, 9);
                rw = (r < 4) || (r == 9);
                rl = (r >= 4 && r < 8) || (r == 9);
            end
            step(rw, rl, 1'($urandom_range(0, 63) == 0));
        end

        // Async reset in the middle of a held round
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        lose_round();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_win", 32'(win_bcd), 32'h00);
        chk("arst_lose", 32'(lose_bcd), 32'h00);
        chk("arst_an", 32'(an), 32'(4'b1110));
        chk("arst_seg", 32'(seg), 32'(7'b1000000));
        #1 rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_count", 32'(win_bcd), 32'h01);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_score.md
# guess_score

Scorekeeper on the consuming end of the guessing-game FSM's `win`/`lose` outputs. Counts one win or one loss per finished round, regardless of how long the game holds the flag. Keeps two saturating 2-digit BCD tallies and drives a time-multiplexed 4-digit seven-segment display on the board. Sits between the game FSM and the board display pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per display digit slot. Range 2 or more; the bench uses 4.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `win`  in  1  game win flag (level; held while the game shows a win).
- `lose`  in  1  game lose flag (level; held while the game shows a loss).
- `clr`  in  1  synchronous score clear, from an already-conditioned button.
- `win_bcd`  out  8  wins tally, BCD: [7:4] tens, [3:0] ones.
- `lose_bcd`  out  8  losses tally, BCD: [7:4] tens, [3:0] ones.
- `an`  out  4  digit enables, active-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, HOLD.
- **IDLE**
  - `win` = 1 and `lose` = 0 → wins +1, go to HOLD.
  - `lose` = 1 and `win` = 0 → losses +1, go to HOLD.
  - Both 1 → illegal; no count, stay in IDLE.
  - Both 0 → stay in IDLE.
- **HOLD**
  - No counting.
  - Both `win` and `lose` = 0 → go to IDLE.
  - Result: exactly one count per assertion of a flag.
- **Tallies**
  - Decimal 00–99, BCD-correct: 09 → 10, 19 → 20, and so on.
  - Saturate at 99: an increment at 99 leaves 99, but the FSM still moves to HOLD.
  - Ones digit never takes a value in 10–15.
- **`clr`** (synchronous)
  - Zeroes both tallies and forces the FSM to IDLE.
  - Takes priority over a same-cycle count event.
  - A flag still high after clr is counted on the next cycle: the FSM is in IDLE and the flag is high. This is intended.
- **Display scan**
  - A divider counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - Digit 0 = wins ones, `an`=1110. Digit 1 = wins tens, `an`=0111... no: digit 1 uses `an`=1101. Digit 2 = losses ones, `an`=1011. Digit 3 = losses tens, `an`=0111.
  - `seg` shows standard decimal glyphs, active-low: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - No leading-zero blanking.
  - The divider and scan are not affected by `clr`.

## Timing
- **Reset values:** FSM IDLE, `win_bcd`=00, `lose_bcd`=00, divider 0, digit index 0, `an`=1110, `seg`=1000000.
- Reset applies immediately and asynchronously, including mid-round. After release, a flag that is still high is counted once on the first clock edge.
- **Count latency:** flag sampled high at edge N in IDLE → tally output shows the new value after edge N (registered, 1 cycle).
- **Back-to-back rounds:** `win` falls at edge N, so the FSM returns to IDLE at N. If `lose` is high at edge N+1, losses increment at N+1.
- **Flag swap without a gap:** win→lose with no cycle where both are 0 gives no second count. The FSM stays in HOLD until both are 0.
- **Display outputs:** `an` and `seg` are registered.
  - Digit switches on the edge after the divider reaches REFRESH_DIV-1, so each digit is held exactly REFRESH_DIV cycles.
  - `seg` reflects the tally value as of the previous cycle (1-cycle display lag after a count).
- No combinational path from inputs to outputs.

## Structure
- Package `guess_pkg`:
  - State enum `score_state_t` {IDLE, HOLD}.
  - Seven-segment glyph constants `SEG_0`..`SEG_9`.
  - Digit-enable constants `AN_D0`..`AN_D3`.
- Sub-module `bcd_counter2`:
  - Ports: `clk`, `rst`, `clr`, `inc`, `q[7:0]`.
  - Two-digit saturating BCD counter with `clr` priority over `inc`.
  - Instantiated twice, once for wins and once for losses.
- Top level holds the FSM, the refresh divider, the digit mux and the glyph decode.

## Test plan
- **Reset, then single win pulse:** `win` high for 5 cycles → `win_bcd`=01 one cycle after the first sample, stays 01, `lose_bcd`=00.
- **Held and swapped flags:** `win` 3 cycles, then `lose` 3 cycles with no gap, then both 0, then `lose` 1 cycle → `win_bcd`=01, `lose_bcd`=01.
- **Wrap and saturation:** 9 wins → 09, 10th → 10; 99 wins then 1 more → 99. Ones digit never takes a value in 10–15.
- **Illegal and priority cases:** `win` = `lose` = 1 in IDLE → no change. `clr` in the same cycle as a `win` sample → both tallies 00.
- **Display scan (REFRESH_DIV=4, wins=37, losses=05):** `an` sequence 1110/1101/1011/0111, 4 cycles each.
  - `seg` sequence 1111000 (7), 0110000 (3), 0010010 (5), 1000000 (0).
  - Sequence repeats.
- **Async reset mid-HOLD with tallies non-zero:** `rst` pulse between clock edges → outputs at reset values immediately.
